spi_frame_feeder: RTL

- Upstream stage for spi_master: queues multi-byte command frames, such as motor-driver register writes.
- Presents each frame to the master as one contiguous txd/txdv burst.
- Waits for the master's done pulse, then enforces a minimum inter-frame gap before the next frame.
- Provides a done timeout, sticky error flags and a sent-frame counter for the host interface.

---
 rtl/spi_frame_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_frame_feeder.sv
// spi_frame_feeder
//   Queues multi-byte command frames and hands each one to spi_master as a
//   single contiguous txd/txdv burst (most significant byte first). After the
//   burst it waits for spi_done (bounded by TIMEOUT), then holds off for the
//   inter-frame gap before starting the next queued frame.
//
// Ports
//   c            clock
//   rst_n        synchronous reset, active low
//   cmd_d        frame word (NBYTES*W bits)
//   cmd_dv       frame write strobe, one frame per high cycle
//   cmd_full     queue full; a write in this cycle is rejected
//   txd / txdv   byte stream to spi_master; txd is 0 whenever txdv is 0
//   spi_done     one-cycle completion pulse from spi_master
//   idle         queue empty and FSM idle
//   overflow     sticky: a write was rejected while full
//   timeout_err  sticky: spi_done did not arrive in time
//   frames_sent  frames completed with spi_done (wraps)
module spi_frame_feeder #(
  parameter int W          = 8,
  parameter int NBYTES     = 2,
  parameter int QD_LOG2    = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 20000
) (
  input  logic                  c,
  input  logic                  rst_n,
  input  logic [NBYTES*W-1:0]   cmd_d,
  input  logic                  cmd_dv,
  output logic                  cmd_full,
  output logic [W-1:0]          txd,
  output logic                  txdv,
  input  logic                  spi_done,
  output logic                  idle,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic [15:0]           frames_sent
);

  localparam int FW    = NBYTES * W;
  localparam int DEPTH = 1 << QD_LOG2;
  localparam int BCW   = $clog2(NBYTES) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_WAIT_DONE, ST_GAP} state_t;

  // The ST_IDLE cycle that pops the next frame counts as the last gap cycle,
  // so ST_GAP itself lasts GAP_CYCLES-1 cycles (skipped when GAP_CYCLES==1).
  // This puts the next txdv rise exactly GAP_CYCLES+1 cycles after spi_done.
  localparam state_t GAP_NEXT = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;

  state_t              state;

  // ---------------- command queue ----------------
  logic [FW-1:0]       mem [DEPTH];
  logic [QD_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [QD_LOG2:0]    count;
  logic                q_empty, push, pop;
  logic [FW-1:0]       head;

  // Full is taken from start-of-cycle occupancy, so a same-cycle pop does not
  // make room for a write that arrives while full.
  assign cmd_full = (count == (QD_LOG2+1)'(DEPTH));
  assign q_empty  = (count == '0);
  assign push     = cmd_dv & ~cmd_full;
  assign pop      = (state == ST_IDLE) & ~q_empty;
  assign head     = mem[rd_ptr];
  assign idle     = (state == ST_IDLE) & q_empty;

  always_ff @(posedge c) begin
    if (push) mem[wr_ptr] <= cmd_d;
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QD_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + QD_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (QD_LOG2+1)'(1);
        2'b01:   count <= count - (QD_LOG2+1)'(1);
        default: ;
      endcase
      if (cmd_dv && cmd_full) overflow <= 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  logic [FW-1:0]  sh;     // bytes still to be sent, next one in the top W bits
  logic [BCW-1:0] bcnt;   // index of the byte currently on txd
  logic [31:0]    tcnt;
  logic [31:0]    gcnt;

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sh          <= '0;
      bcnt        <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      txd         <= '0;
      txdv        <= 1'b0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            // Byte 0 goes straight out; the shifter keeps the rest.
            txd   <= head[FW-1 -: W];
            txdv  <= 1'b1;
            sh    <= head << W;
            bcnt  <= '0;
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bcnt == BCW'(NBYTES-1)) begin
            txd   <= '0;
            txdv  <= 1'b0;
            tcnt  <= '0;
            state <= ST_WAIT_DONE;
          end else begin
            txd  <= sh[FW-1 -: W];
            sh   <= sh << W;
            bcnt <= bcnt + BCW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (spi_done) begin
            frames_sent <= frames_sent + 16'd1;
            gcnt        <= '0;
            state       <= GAP_NEXT;
          end else if (tcnt == 32'(TIMEOUT-1)) begin
            timeout_err <= 1'b1;
            gcnt        <= '0;
            state       <= GAP_NEXT;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        ST_GAP: begin
          // spi_done is deliberately ignored here (late completion).
          if (gcnt == 32'(GAP_CYCLES-2)) state <= ST_IDLE;
          else                           gcnt  <= gcnt + 32'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
